tdm_flow_arbiter: RTL and testbench

Time-division arbiter that shares one output register between two requesters: A (untrusted/tainted) and B (trusted).
- Grants follow a fixed schedule that never depends on either requester's activity, so B's grant timing cannot reveal anything about A, and the reverse.
- A one-cycle scrub zeroes the shared register between slots, so no A data reaches B's slot and no B data reaches A's slot.
- Sits in front of the shared sink register of an information-flow-checked datapath and sequences all writes to it.

---
 rtl/tdm_flow_arbiter.sv | 114 +++++++++++
 tb/tb_tdm_flow_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_flow_arbiter.sv
// Fixed-schedule TDM arbiter sharing one output register between an untrusted (A)
// and a trusted (B) requester, with a one-cycle scrub between slots.
module tdm_flow_arbiter #(
    parameter int WIDTH    = 8,
    parameter int SLOT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             slot_start,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_owner
);

    localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_LEN - 1);

    localparam logic [1:0] S_SCRUB_A = 2'd0;
    localparam logic [1:0] S_SLOT_A  = 2'd1;
    localparam logic [1:0] S_SCRUB_B = 2'd2;
    localparam logic [1:0] S_SLOT_B  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             owner_q, owner_d;
    logic             inScrub;
    logic             cntLast;

    assign inScrub    = (state_q == S_SCRUB_A) || (state_q == S_SCRUB_B);
    assign cntLast    = (cnt_q == CNT_LAST);
    assign gnt_a      = (state_q == S_SLOT_A) && req_a;
    assign gnt_b      = (state_q == S_SLOT_B) && req_b;
    assign slot_start = !inScrub && (cnt_q == '0);

    // The schedule advances purely on the counter; requests never influence it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_SCRUB_A: begin
                state_d = S_SLOT_A;
                cnt_d   = '0;
            end
            S_SLOT_A: begin
                if (cntLast) begin
                    state_d = S_SCRUB_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SCRUB_B: begin
                state_d = S_SLOT_B;
                cnt_d   = '0;
            end
            default: begin
                if (cntLast) begin
                    state_d = S_SCRUB_A;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Scrub clears the shared register so nothing crosses from one slot to the next.
    always_comb begin
        data_d  = data_q;
        owner_d = owner_q;
        valid_d = 1'b0;
        if (inScrub) begin
            data_d  = '0;
            owner_d = 1'b0;
        end else if (gnt_a) begin
            data_d  = data_a;
            owner_d = 1'b0;
            valid_d = 1'b1;
        end else if (gnt_b) begin
            data_d  = data_b;
            owner_d = 1'b1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SCRUB_A;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            owner_q <= owner_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_owner = owner_q;

endmodule

// File: tb/tb_tdm_flow_arbiter.sv
// Directed self-checking bench for tdm_flow_arbiter (WIDTH=8, SLOT_LEN=4, period 10).
module tb_tdm_flow_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic [7:0] data_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       slot_start;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_owner;

    int passCount = 0;
    int totalCount = 0;

    tdm_flow_arbiter #(.WIDTH(8), .SLOT_LEN(4)) dut (
        .clk(clk),
        .rst(rst),
        .req_a(req_a),
        .data_a(data_a),
        .req_b(req_b),
        .data_b(data_b),
        .gnt_a(gnt_a),
        .gnt_b(gnt_b),
        .slot_start(slot_start),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_owner(out_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench 1 time unit into cycle 0 with rst released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] obs, exp;
        req_a = 1'b1; data_a = 8'hAA; req_b = 1'b0; data_b = 8'h00;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            rst = (c == 3);
            @(negedge clk);
            obs = {gnt_a, gnt_b, slot_start, out_valid, out_owner, out_data};
            case (c)
                0:       exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
                1:       exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
                2:       exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA};
                3:       exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA};
                4:       exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
                default: exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
            endcase
            totalCount++;
            if (obs !== exp)
                $display("[TB] FAIL reset cycle %0d: got %b required %b", c, obs, exp);
            else
                passCount++;
            next_cycle();
        end
        rst = 1'b0; req_a = 1'b0;
    endtask

    task automatic test_idle_schedule();
        logic [12:0] obs, exp;
        req_a = 1'b0; req_b = 1'b0; data_a = 8'h11; data_b = 8'h22;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            obs = {gnt_a, gnt_b, slot_start, out_valid, out_owner, out_data};
            exp = {1'b0, 1'b0, ((c % 10) == 1) || ((c % 10) == 6), 1'b0, 1'b0, 8'h00};
            totalCount++;
            if (obs !== exp)
                $display("[TB] FAIL idle cycle %0d: got %b required %b", c, obs, exp);
            else
                passCount++;
            next_cycle();
        end
    endtask

    task automatic test_single_a();
        logic [10:0] obs, exp;
        req_a = 1'b1; data_a = 8'h5A; req_b = 1'b0; data_b = 8'h00;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs = {gnt_a, out_valid, out_owner, out_data};
            exp = {(c >= 1 && c <= 4), (c >= 2 && c <= 5), 1'b0,
                   (c >= 2 && c <= 5) ? 8'h5A : 8'h00};
            totalCount++;
            if (obs !== exp)
                $display("[TB] FAIL single_a cycle %0d: got %b required %b", c, obs, exp);
            else
                passCount++;
            next_cycle();
        end
        req_a = 1'b0;
    endtask

    task automatic test_scrub_isolation();
        logic [10:0] obs, exp;
        req_b = 1'b0; data_b = 8'h00;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            req_a  = (c == 4);
            data_a = (c == 4) ? 8'hFF : 8'h00;
            @(negedge clk);
            obs = {gnt_a, out_valid, out_owner, out_data};
            exp = {(c == 4), (c == 5), 1'b0, (c == 5) ? 8'hFF : 8'h00};
            totalCount++;
            if (obs !== exp)
                $display("[TB] FAIL scrub_iso cycle %0d: got %b required %b", c, obs, exp);
            else
                passCount++;
            next_cycle();
        end
        req_a = 1'b0;
    endtask

    // B's observable behaviour must be identical whatever A does.
    task automatic test_non_interference(input logic aLevel);
        logic [10:0] obs, exp;
        req_a = aLevel; data_a = 8'hA5;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            req_b  = (c >= 6 && c <= 9);
            data_b = (c >= 6 && c <= 9) ? 8'h33 : 8'h00;
            @(negedge clk);
            totalCount++;
            if (gnt_b !== (c >= 6 && c <= 9))
                $display("[TB] FAIL noninterf a=%0b cycle %0d gnt_b: got %b required %b",
                         aLevel, c, gnt_b, (c >= 6 && c <= 9));
            else
                passCount++;
            if (c >= 6) begin
                obs = {out_valid, out_owner, out_data, 1'b0};
                exp = (c == 6) ? {1'b0, 1'b0, 8'h00, 1'b0} : {1'b1, 1'b1, 8'h33, 1'b0};
                totalCount++;
                if (obs !== exp)
                    $display("[TB] FAIL noninterf a=%0b cycle %0d out: got %b required %b",
                             aLevel, c, obs, exp);
                else
                    passCount++;
            end
            next_cycle();
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_out_of_slot();
        req_a = 1'b0; data_a = 8'h00; data_b = 8'h44;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            req_b = (c <= 5);
            @(negedge clk);
            totalCount++;
            if ({gnt_b, out_owner} !== 2'b00)
                $display("[TB] FAIL out_of_slot cycle %0d: got gnt_b/owner %b required 00",
                         c, {gnt_b, out_owner});
            else
                passCount++;
            next_cycle();
        end
        req_b = 1'b0;
    endtask

    task automatic test_reset_mid_slot();
        logic [12:0] obs, exp;
        req_a = 1'b0; data_a = 8'h00; req_b = 1'b1; data_b = 8'h77;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            rst = (c == 8);
            @(negedge clk);
            obs = {gnt_a, gnt_b, slot_start, out_valid, out_owner, out_data};
            case (c)
                8:       exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77};
                9:       exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
                10:      exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
                15:      exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
                default: exp = obs;
            endcase
            if (c == 8 || c == 9 || c == 10 || c == 15) begin
                totalCount++;
                if (obs !== exp)
                    $display("[TB] FAIL reset_mid cycle %0d: got %b required %b", c, obs, exp);
                else
                    passCount++;
            end
            next_cycle();
        end
        rst = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; data_a = 8'h00; req_b = 1'b0; data_b = 8'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_idle_schedule();
        test_single_a();
        test_scrub_isolation();
        test_non_interference(1'b0);
        test_non_interference(1'b1);
        test_out_of_slot();
        test_reset_mid_slot();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
